// File: rtl/lfsr_sig_monitor.sv
// lfsr_sig_monitor: watches an 8-bit LFSR pattern stream. After a start pulse
// the first pattern becomes the seed. Each later pattern yields a record
// {hamming distance to previous pattern, pattern} in a small FIFO. The block
// also accumulates a saturating distance sum and detects seed recurrence.
// Optional feature macro: LFSR_MON_MISR_EN builds an 8-bit MISR signature over
// the pattern stream; without it misr is tied to zero.
module lfsr_sig_monitor #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] MISR_POLY  = 8'hB8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pat_valid,
  input  logic [7:0]  pat,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [11:0] rec_data,
  output logic [11:0] hd_sum,
  output logic [7:0]  period,
  output logic        period_found,
  output logic [7:0]  misr,
  output logic        overflow,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_seed, r_prev, r_count, r_period;
  logic [11:0] r_hd_sum;
  logic        r_found, r_ovf;
  logic [11:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;

  logic        w_run_smp, w_empty, w_full, w_pop, w_push;
  logic [7:0]  w_diff;
  logic [3:0]  w_hd;
  logic [12:0] w_sum;

  // A RUN sample counts only when start is not pulsing the same cycle
  assign w_run_smp = (r_state == RUN) && pat_valid && !start;
  assign w_diff    = pat ^ r_prev;
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && rec_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign w_push    = w_run_smp && (!w_full || w_pop);
  assign w_sum     = {1'b0, r_hd_sum} + {9'b0, w_hd};

  // Popcount of the bit difference against the previous pattern
  always_comb begin
    w_hd = '0;
    for (int i = 0; i < 8; i++) w_hd = w_hd + {3'b0, w_diff[i]};
  end

  // FIFO storage; contents are masked by the empty flag so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {w_hd, pat};
  end

  // FIFO pointers; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Capture FSM with seed/recurrence tracking and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_seed   <= '0;
      r_prev   <= '0;
      r_count  <= '0;
      r_period <= '0;
      r_hd_sum <= '0;
      r_found  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (start) begin
      r_state  <= SEED;
      r_count  <= '0;
      r_period <= '0;
      r_hd_sum <= '0;
      r_found  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        SEED: if (pat_valid) begin
          r_seed  <= pat;
          r_prev  <= pat;
          r_count <= 8'd1;
          r_state <= RUN;
        end
        RUN: if (pat_valid) begin
          r_hd_sum <= w_sum[12] ? 12'hFFF : w_sum[11:0];
          r_prev   <= pat;
          r_count  <= r_count + 8'd1;
          if (!w_push) r_ovf <= 1'b1;
          // Recurrence wins over count saturation on the same sample
          if (pat == r_seed) begin
            r_period <= r_count + 8'd1;
            r_found  <= 1'b1;
            r_state  <= DONE;
          end else if (r_count == 8'd254) begin
            r_state  <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LFSR_MON_MISR_EN
  logic [7:0] r_misr;
  // Signature register folds each RUN pattern into a shifted feedback word
  always_ff @(posedge clk) begin
    if (!rst_n || start) r_misr <= '0;
    else if (w_run_smp)  r_misr <= {r_misr[6:0], ^(r_misr & MISR_POLY)} ^ pat;
  end
  assign misr = r_misr;
`else
  logic w_unused_poly;
  assign w_unused_poly = ^MISR_POLY;
  assign misr = 8'h00;
`endif

  assign rec_valid    = !w_empty;
  assign rec_data     = w_empty ? 12'h000 : r_mem[r_rptr[AW-1:0]];
  assign hd_sum       = r_hd_sum;
  assign period       = r_period;
  assign period_found = r_found;
  assign overflow     = r_ovf;
  assign busy         = (r_state == SEED) || (r_state == RUN);
endmodule

// File: doc/lfsr_sig_monitor.md
LFSR_SIG_MONITOR -- requirements
Module: lfsr_sig_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FIFO_DEPTH, 4, sample FIFO entries (power of two, 2..16).
- MISR_POLY, 8'hB8, MISR feedback tap mask.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle pulse; arms a new capture and clears all statistics.
- pat_valid, in, 1, a new LFSR pattern is present on pat this cycle.
- pat, in, 8, LFSR pattern from the generator stage (bit 0 = stage Q[0]).
- rec_valid, out, 1, FIFO head record available.
- rec_ready, in, 1, consumer accepts the head record.
- rec_data, out, 12, {hd[3:0], pat[7:0]} of the FIFO head.
- hd_sum, out, 12, accumulated Hamming distance, saturating.
- period, out, 8, pattern count at which the seed recurred.
- period_found, out, 1, seed recurrence detected.
- misr, out, 8, signature of the pattern stream.
- overflow, out, 1, sticky flag: a sample was dropped on FIFO full.
- busy, out, 1, high in SEED or RUN.

Function
REQ-003 The FSM SHALL have states IDLE, SEED, RUN and DONE.
REQ-004 Transitions:
- start moves IDLE, RUN or DONE to SEED.
- The first pat_valid in SEED moves to RUN.
- Seed recurrence or count saturation in RUN moves to DONE.
- start in SEED re-enters SEED.
REQ-005 On start, the block SHALL clear hd_sum, period, period_found, misr, overflow, the pattern count and the FIFO in the same edge.
REQ-006 On the first pat_valid in SEED, the block SHALL latch seed = pat and prev = pat, and set count = 1; no sample is pushed.
REQ-007 On each pat_valid in RUN, the block SHALL:
- compute hd = popcount(pat ^ prev), range 0..8;
- push {hd, pat};
- add hd to hd_sum;
- update misr;
- set prev = pat and count = count + 1.
REQ-008 If pat == seed in RUN, the block SHALL also set period = count + 1 and period_found = 1, and enter DONE; that sample is still pushed.
REQ-009 If count + 1 reaches 255 in RUN without recurrence, the block SHALL enter DONE with period_found = 0 and period = 0.
REQ-010 pat_valid in IDLE or DONE SHALL be ignored.
REQ-011 hd_sum SHALL saturate at 12'hFFF and never wrap.
REQ-012 Pushes, statistics and state changes SHALL take effect on the edge after pat_valid; rec_valid SHALL rise on the following cycle at the earliest (1-cycle latency).
REQ-013 A record SHALL pop when rec_valid && rec_ready; rec_data SHALL hold stable while rec_valid && !rec_ready.
REQ-014 A push while full without a simultaneous pop SHALL drop the sample and set overflow; a push while full with a simultaneous pop SHALL succeed.
REQ-015 A pop while empty SHALL have no effect; rec_valid = 0 whenever the FIFO is empty.
REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH; ordering SHALL be strict FIFO.
REQ-017 start SHALL take priority over a simultaneous pat_valid; that pattern is not captured as seed.

Reset
REQ-018 With rst_n = 0 at a rising edge, the block SHALL enter IDLE and empty the FIFO.
REQ-019 During reset, all outputs SHALL be 0: rec_valid, rec_data, hd_sum, period, period_found, misr, overflow, busy.
REQ-020 Reset mid-RUN SHALL discard all FIFO contents and statistics.

Configuration
REQ-021 With LFSR_MON_MISR_EN defined, misr_next SHALL be {misr[6:0], ^(misr & MISR_POLY)} ^ pat on every RUN sample.
REQ-022 With LFSR_MON_MISR_EN undefined, no MISR logic SHALL be built and misr SHALL be tied to 8'h00.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then start, then pats 01, 03, 07 -> records {1,03}, {1,07}; hd_sum = 2; busy = 1.
- Seed 8'h5A, then 8'hA5, 8'h5A -> records {8,A5}, {8,5A}; period = 3; period_found = 1; state DONE; later pats ignored.
- FIFO_DEPTH = 4, rec_ready = 0, six RUN pats -> four records kept in order; overflow = 1; a fifth push with a simultaneous pop succeeds.
- 255 pats with no seed recurrence -> DONE; period_found = 0; period = 0.
- MISR_EN defined, misr = 0, pats 01, 02 after seed -> misr = 01, then 00; MISR_EN undefined -> misr = 00.
- rst_n low mid-RUN with 3 records queued -> rec_valid = 0, all statistics 0, IDLE; start together with pat_valid -> no seed latched.
